uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Buffering and pacing stage directly upstream of the UART TX path (tx_start/tx_data/tx_active/tx_done of uart_full_duplex).
- Accepts bytes from a producer over a valid/ready handshake and stores them in a synchronous FIFO.
- Launches one UART frame per byte, then waits for frame completion and an optional inter-frame gap before launching the next.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden).
- GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next tx_start; 0 means no gap.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  producer byte valid.
- in_data  in  8  producer byte.
- in_ready  out  1  FIFO can accept a byte; equals !fifo_full.
- tx_start  out  1  one-cycle launch pulse to the UART TX.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- tx_active  in  1  UART TX busy.
- tx_done  in  1  UART TX frame-complete pulse.
- fifo_count  out  AW+1  bytes currently stored.
- fifo_empty  out  1  fifo_count == 0.
- fifo_full  out  1  fifo_count == DEPTH.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous) clears:
  - FIFO pointers and count; fifo_count = 0, fifo_empty = 1, fifo_full = 0, in_ready = 1.
  - tx_start = 0, tx_data = 8'h00, busy = 0; FSM to IDLE; gap counter to 0.
  - A frame in progress is abandoned. No tx_start is issued until after reset deasserts.
- Write: a byte is accepted on a rising edge where in_valid && in_ready. The byte is appended at the write pointer.
- Pop: the FSM reads the head in IDLE. A push and a pop on the same edge with a non-empty FIFO leave the count unchanged.
- Full FIFO: in_ready = 0, so no push is possible even if a pop happens on the same edge.
- Pointers wrap modulo DEPTH; count is kept separately to distinguish full from empty.
- FSM states: IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, GAP.
  - IDLE: if !fifo_empty && !tx_active, pop the head into tx_data, set tx_start = 1, go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start returns to 0 (pulse width is exactly 1 cycle). Go to WAIT_ACTIVE.
  - WAIT_ACTIVE: tx_done = 1 goes to GAP (short frame). Else tx_active = 1 goes to WAIT_DONE. Else stay.
  - WAIT_DONE: tx_done = 1 goes to GAP. Otherwise stay.
  - GAP: if GAP_CYCLES == 0, go to IDLE on the next edge. Otherwise count GAP_CYCLES clocks, then go to IDLE.
- Latency: a byte written into an empty FIFO while the FSM is idle is accepted at edge k. fifo_empty = 0 after edge k, and tx_start is high from edge k+1 to edge k+2.
- Back-to-back spacing: the next tx_start is at least GAP_CYCLES+2 clocks after the tx_done cycle.
- tx_data changes only on the pop edge.
- flush = 1 resets the FIFO pointers and count on that edge; any same-cycle write is discarded. The byte already popped continues to completion (FSM not aborted).
- A flush and a pop on the same edge: the pop wins for tx_data, and the count ends at 0.
- A tx_done that arrives in IDLE or GAP is ignored.

Decomposition:
- Shared package uart_pkg:
  - localparam UART_DATA_W = 8.
  - enum typedef uart_feed_state_t {IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, GAP}.
- One sub-module, uart_sync_fifo (parameters DEPTH, DATA_W), which holds storage, pointers, count, full/empty and the flush input.
- The FSM and gap counter stay in uart_tx_feeder.

Test Plan:
- Reset and idle: assert reset for 3 cycles, then release -> fifo_count = 0, in_ready = 1, tx_start never asserted, busy = 0.
- Single byte: write 8'hA5 at edge k into the empty feeder -> tx_start high for exactly one cycle after edge k+1 with tx_data = 8'hA5. The model raises tx_active, then pulses tx_done -> busy = 0 after GAP.
- Fill and drain: DEPTH = 16 with a held-busy TX model; write 0x00..0x10 -> 16 accepted, in_ready = 0 on the 17th. Release the TX model -> bytes go out in order 0x00..0x0F, and fifo_count decrements to 0.
- Gap: GAP_CYCLES = 4, two queued bytes, tx_done in cycle t -> second tx_start in cycle t+6, and no earlier.
- Flush mid-frame: 5 bytes queued, first byte in WAIT_DONE, flush pulse -> fifo_count = 0 next cycle. The first frame still completes, and no further tx_start occurs.
- Async reset mid-frame: drop reset during WAIT_DONE with 3 bytes queued -> tx_data = 0, fifo_count = 0 immediately. After release, no tx_start occurs even if tx_done pulses.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_pkg                                                |
// | Description : Shared constants and types for the UART TX feeder:     |
// |               byte width and the feeder FSM state encoding.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LAUNCH      = 3'd1,
    WAIT_ACTIVE = 3'd2,
    WAIT_DONE   = 3'd3,
    GAP         = 3'd4
  } uart_feed_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                          |
// | Description : Single-clock FIFO with separate occupancy count and a  |
// |               synchronous flush. Head byte is presented              |
// |               combinationally on rd_data.                            |
// | Ports       : clk, reset (async, active-low), flush,                 |
// |               wr_en/wr_data (push, ignored when full or flushing),   |
// |               rd_en (pop, ignored when empty), rd_data (head),       |
// |               count, empty, full.                                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A flush discards any write presented on the same edge.
  assign do_push = wr_en && !full && !flush;
  assign do_pop  = rd_en && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush dominates a same-edge pop: count ends at zero either way.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_tx_feeder                                          |
// | Description : Buffers producer bytes in a FIFO and launches one UART |
// |               TX frame per byte, waiting for frame completion and an |
// |               optional inter-frame gap between launches.             |
// | Ports       : clk, reset (async, active-low), flush (FIFO clear),    |
// |               in_valid/in_data/in_ready (producer handshake),        |
// |               tx_start/tx_data (launch to UART TX),                  |
// |               tx_active/tx_done (UART TX status),                    |
// |               fifo_count/fifo_empty/fifo_full, busy (FSM not idle).  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int  DEPTH      = 16,
  parameter int  GAP_CYCLES = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic [AW:0]            fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   busy
);

  // Gap counter sized for GAP_CYCLES-1; a zero gap still spends one cycle
  // in GAP, which gives the minimum launch spacing.
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 1) : '0;

  uart_feed_state_t       state;
  uart_feed_state_t       next_state;
  logic [GW-1:0]          gap_cnt;
  logic                   gap_done;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign in_ready = !fifo_full;
  assign gap_done = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (!fifo_empty && !tx_active) next_state = LAUNCH;
      LAUNCH:      next_state = WAIT_ACTIVE;
      WAIT_ACTIVE: begin
        // A frame short enough to finish before tx_active is seen still counts.
        if (tx_done)        next_state = GAP;
        else if (tx_active) next_state = WAIT_DONE;
      end
      WAIT_DONE:   if (tx_done) next_state = GAP;
      GAP:         if (gap_done) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pop      = (state == IDLE) && !fifo_empty && !tx_active;
    tx_start = (state == LAUNCH);
    busy     = (state != IDLE);
  end

  // tx_data only moves on the pop edge, so it stays stable for the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   tx_data <= '0;
    else if (pop) tx_data <= fifo_head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              gap_cnt <= '0;
    else if (state == GAP)   gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_tx_feeder                                       |
// | Description : Scoreboard bench for uart_tx_feeder (DEPTH=16,         |
// |               GAP_CYCLES=4) with a small UART TX response model.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int GAP     = 4;
  localparam int FRAME   = 3;
  localparam int MIN_SEP = GAP + 2;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       busy;

  logic model_active;
  logic hold_active;
  logic tx_hold;
  assign tx_active = model_active | hold_active;

  uart_tx_feeder #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: bytes are pushed when accepted, popped when launched.
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] launched = 8'h00;
  logic       prev_start = 1'b0;
  int         start_count = 0;
  int         last_gap = 0;
  int         done_cyc = 0;
  bit         have_done = 1'b0;

  // TX model: one cycle after tx_start it goes active, stays active for
  // FRAME cycles (longer while tx_hold), then drops and pulses tx_done.
  initial begin
    model_active = 1'b0;
    tx_done      = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1;
        model_active = 1'b1;
        repeat (FRAME) begin @(posedge clk); #1; end
        while (tx_hold) begin @(posedge clk); #1; end
        model_active = 1'b0;
        tx_done      = 1'b1;
        done_cyc     = cyc;
        have_done    = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (tx_start) begin
      start_count++;
      check("start_pulse_width", prev_start, 1'b0);
      check("start_has_queued_byte", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("tx_data_order", tx_data, exp_b);
        check("count_after_pop", fifo_count, exp_q.size());
      end
      launched = tx_data;
      if (have_done) begin
        last_gap = cyc - done_cyc;
        check("gap_min_spacing", last_gap >= MIN_SEP, 1'b1);
      end
    end else if (busy) begin
      check("tx_data_hold", tx_data, launched);
    end
    prev_start = tx_start;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic write_byte(input logic [7:0] b, input logic accept);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    check("in_ready", in_ready, accept);
    @(posedge clk);
    if (accept) exp_q.push_back(b);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && fifo_empty == 1'b1) && n < budget);
    check(name, (busy == 1'b0 && fifo_empty == 1'b1), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n = 0;
    while (start_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, start_count >= target, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    hold_active = 1'b0;
    tx_hold     = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_count", fifo_count, 0);
    check("idle_empty", fifo_empty, 1'b1);
    check("idle_full", fifo_full, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_no_start", start_count, 0);
    @(posedge clk); #1;

    // Single byte: accepted at edge k, tx_start between edges k+1 and k+2
    write_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("single_no_early_start", tx_start, 1'b0);
    check("single_count", fifo_count, 1);
    check("single_not_empty", fifo_empty, 1'b0);
    @(negedge clk);
    check("single_start", tx_start, 1'b1);
    check("single_data", tx_data, 8'hA5);
    @(posedge clk); #1;
    wait_idle("single_idle_timeout", 100);
    check("single_busy_end", busy, 1'b0);

    // Fill and drain with the TX held busy
    hold_active = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b1);
    @(negedge clk);
    check("fill_count", fifo_count, DEPTH);
    check("fill_full", fifo_full, 1'b1);
    @(posedge clk); #1;
    write_byte(8'h10, 1'b0);
    @(negedge clk);
    check("fill_count_after_reject", fifo_count, DEPTH);
    @(posedge clk); #1;
    base = start_count;
    hold_active = 1'b0;
    wait_idle("drain_timeout", 400);
    check("drain_starts", start_count - base, DEPTH);
    check("drain_count", fifo_count, 0);

    // Gap: second launch exactly GAP+2 cycles after the tx_done cycle
    hold_active = 1'b1;
    write_byte(8'h3C, 1'b1);
    write_byte(8'hC3, 1'b1);
    base = start_count;
    hold_active = 1'b0;
    wait_starts("gap_start_timeout", base + 2, 100);
    check("gap_exact", last_gap, MIN_SEP);
    wait_idle("gap_idle_timeout", 100);

    // Flush mid-frame (with a same-edge write that must be dropped)
    hold_active = 1'b1;
    for (int i = 1; i <= 5; i++) write_byte(8'(i * 8'h11), 1'b1);
    tx_hold = 1'b1;
    base = start_count;
    hold_active = 1'b0;
    wait_starts("flush_start_timeout", base + 1, 50);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("flush_pre_count", fifo_count, 4);
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_count", fifo_count, 0);
    check("flush_empty", fifo_empty, 1'b1);
    check("flush_frame_continues", busy, 1'b1);
    @(posedge clk); #1;
    tx_hold = 1'b0;
    wait_idle("flush_idle_timeout", 100);
    repeat (15) @(posedge clk);
    #1;
    check("flush_no_more_starts", start_count, base + 1);

    // Asynchronous reset mid-frame
    hold_active = 1'b1;
    write_byte(8'hAA, 1'b1);
    write_byte(8'hBB, 1'b1);
    write_byte(8'hCC, 1'b1);
    write_byte(8'hDD, 1'b1);
    tx_hold = 1'b1;
    base = start_count;
    hold_active = 1'b0;
    wait_starts("areset_start_timeout", base + 1, 50);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("areset_pre_count", fifo_count, 3);
    check("areset_pre_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("areset_tx_data", tx_data, 8'h00);
    check("areset_count", fifo_count, 0);
    check("areset_busy", busy, 1'b0);
    check("areset_start", tx_start, 1'b0);
    @(posedge clk); #1;
    reset   = 1'b1;
    tx_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("areset_no_start", start_count, base + 1);
    check("areset_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
